wbu_retire: RTL and testbench

//  Writeback/retire stage at the tail of the IFU->IDU->EXU->LSU pipeline. Accepts completed

---
 rtl/wbu_retire.sv | 104 ++++++++++
 tb/tb_wbu_retire.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_retire.sv
// rtl/wbu_retire.sv - writeback/retire stage: FIFO-buffered regfile write port and commit tracking
// Retires one instruction per cycle from a small FIFO; halts permanently on EBREAK until reset.
module wbu_retire #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_dnpc,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_reg_wen,
  input  logic [31:0]      in_wdata,
  input  logic             in_ebreak,
  input  logic             stall,
  output logic             rf_wen,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_dnpc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [4:0]  rd_addr;
    logic        reg_wen;
    logic [31:0] wdata;
    logic        ebreak;
  } entry_t;

  typedef enum logic {S_RUN, S_HALT} state_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  state_t         state;
  logic           push;
  logic           pop;

  // Readiness depends only on registered state, so upstream never sees a path from stall.
  assign in_ready = (state == S_RUN) && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !stall && (state == S_RUN);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, dnpc: in_dnpc, rd_addr: in_rd_addr,
                       reg_wen: in_reg_wen, wdata: in_wdata, ebreak: in_ebreak};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= S_RUN;
      rf_wen       <= 1'b0;
      rf_addr      <= '0;
      rf_data      <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_dnpc  <= '0;
      retire_cnt   <= '0;
      halted       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      rf_wen       <= pop && head.reg_wen && (head.rd_addr != 5'd0);
      commit_valid <= pop;
      if (pop) begin
        rf_addr     <= head.rd_addr;
        rf_data     <= head.wdata;
        commit_pc   <= head.pc;
        commit_dnpc <= head.dnpc;
        retire_cnt  <= retire_cnt + CNT_W'(1);
        // EBREAK still commits; the halt only blocks entries behind it.
        if (head.ebreak) begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wbu_retire.sv
// tb/tb_wbu_retire.sv - directed table-driven bench for wbu_retire
// A second instance with a 4-bit counter covers counter wraparound.
module tb_wbu_retire;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_dnpc, in_wdata;
  logic [4:0]  in_rd_addr;
  logic        in_reg_wen, in_ebreak, stall;

  logic        in_ready, rf_wen, commit_valid, halted;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, commit_pc, commit_dnpc;
  logic [63:0] retire_cnt;

  logic        in_ready4, rf_wen4, commit_valid4, halted4;
  logic [4:0]  rf_addr4;
  logic [31:0] rf_data4, commit_pc4, commit_dnpc4;
  logic [3:0]  retire_cnt4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wbu_retire dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd_addr(in_rd_addr),
    .in_reg_wen(in_reg_wen), .in_wdata(in_wdata), .in_ebreak(in_ebreak),
    .stall(stall), .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dnpc(commit_dnpc),
    .retire_cnt(retire_cnt), .halted(halted)
  );

  wbu_retire #(.DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd_addr(in_rd_addr),
    .in_reg_wen(in_reg_wen), .in_wdata(in_wdata), .in_ebreak(in_ebreak),
    .stall(stall), .rf_wen(rf_wen4), .rf_addr(rf_addr4), .rf_data(rf_data4),
    .commit_valid(commit_valid4), .commit_pc(commit_pc4), .commit_dnpc(commit_dnpc4),
    .retire_cnt(retire_cnt4), .halted(halted4)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    logic        e_ready;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_cv;
    logic [31:0] e_pc;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic wen, input logic [31:0] wdata, input logic eb);
    in_valid   = v;
    in_pc      = pc;
    in_dnpc    = pc + 32'd4;
    in_rd_addr = rd;
    in_reg_wen = wen;
    in_wdata   = wdata;
    in_ebreak  = eb;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h80000000, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        64'd0};
    vecs[1] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h80000000, 64'd1};
    vecs[2] = '{1'b1, 32'h80000004, 5'd0, 1'b1, 32'h1234,     1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h80000000, 64'd1};
    vecs[3] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 32'h1234,     1'b1, 32'h80000004, 64'd2};
    vecs[4] = '{1'b1, 32'h80000008, 5'd7, 1'b0, 32'h55,       1'b1, 1'b0, 5'd0, 32'h1234,     1'b0, 32'h80000004, 64'd2};
    vecs[5] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd7, 32'h55,       1'b1, 32'h80000008, 64'd3};
    vecs[6] = '{1'b1, 32'h8000000C, 5'd1, 1'b1, 32'h1,        1'b1, 1'b0, 5'd7, 32'h55,       1'b0, 32'h80000008, 64'd3};
    vecs[7] = '{1'b1, 32'h80000010, 5'd2, 1'b1, 32'h2,        1'b1, 1'b1, 5'd1, 32'h1,        1'b1, 32'h8000000C, 64'd4};
    vecs[8] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 5'd2, 32'h2,        1'b1, 32'h80000010, 64'd5};
    vecs[9] = '{1'b0, 32'h0,        5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 5'd2, 32'h2,        1'b0, 32'h80000010, 64'd5};

    rst = 1'b1; stall = 1'b0; idle();
    tick(); tick();
    chk("reset rf_wen", rf_wen, 0);
    chk("reset rf_addr", rf_addr, 0);
    chk("reset rf_data", rf_data, 0);
    chk("reset commit_valid", commit_valid, 0);
    chk("reset commit_pc", commit_pc, 0);
    chk("reset commit_dnpc", commit_dnpc, 0);
    chk("reset retire_cnt", retire_cnt, 0);
    chk("reset halted", halted, 0);
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", in_ready, 1);

    // basic latency, x0 suppression, no-write instr, back-to-back pair
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].rd, vecs[i].wen, vecs[i].wdata, 1'b0);
      tick();
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d rf_wen", i), rf_wen, vecs[i].e_wen);
      chk($sformatf("vec%0d rf_addr", i), rf_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d rf_data", i), rf_data, vecs[i].e_data);
      chk($sformatf("vec%0d commit_valid", i), commit_valid, vecs[i].e_cv);
      chk($sformatf("vec%0d commit_pc", i), commit_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d commit_dnpc", i), commit_dnpc,
          (vecs[i].e_pc == 32'h0) ? 64'h0 : 64'(vecs[i].e_pc + 32'd4));
      chk($sformatf("vec%0d retire_cnt", i), retire_cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d halted", i), halted, 0);
    end

    // stall: only two of four offers accepted, then drained in order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h90000000 + 32'(i * 4), 5'(10 + i), 1'b1, 32'(100 + i), 1'b0);
      tick();
      chk($sformatf("stall%0d in_ready", i), in_ready, (i < 1) ? 1 : 0);
      chk($sformatf("stall%0d commit_valid", i), commit_valid, 0);
    end
    idle(); stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("drain%0d commit_valid", i), commit_valid, 1);
      chk($sformatf("drain%0d commit_pc", i), commit_pc, 32'h90000000 + 32'(i * 4));
      chk($sformatf("drain%0d rf_addr", i), rf_addr, 5'(10 + i));
      chk($sformatf("drain%0d rf_data", i), rf_data, 32'(100 + i));
      chk($sformatf("drain%0d in_ready", i), in_ready, 1);
    end
    tick();
    chk("drain end commit_valid", commit_valid, 0);
    chk("drain end retire_cnt", retire_cnt, 7);

    // eight back-to-back pushes: one commit per cycle, no bubbles
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b1, 32'hA0000000 + 32'(k * 4), 5'(k + 1), 1'b1, 32'(k * 3), 1'b0);
      else idle();
      tick();
      chk($sformatf("b2b%0d in_ready", k), in_ready, 1);
      chk($sformatf("b2b%0d commit_valid", k), commit_valid, (k >= 1 && k <= 8) ? 1 : 0);
      if (k >= 1 && k <= 8) begin
        chk($sformatf("b2b%0d commit_pc", k), commit_pc, 32'hA0000000 + 32'((k - 1) * 4));
        chk($sformatf("b2b%0d rf_data", k), rf_data, 32'((k - 1) * 3));
      end
    end
    chk("b2b retire_cnt", retire_cnt, 15);
    chk("b2b retire_cnt4", retire_cnt4, 15);

    // EBREAK followed by a normal instr
    drive(1'b1, 32'hB0000000, 5'd3, 1'b1, 32'h33, 1'b1);
    tick();
    drive(1'b1, 32'hB0000004, 5'd4, 1'b1, 32'h44, 1'b0);
    tick();
    chk("ebreak commit_valid", commit_valid, 1);
    chk("ebreak commit_pc", commit_pc, 32'hB0000000);
    chk("ebreak rf_wen", rf_wen, 1);
    chk("ebreak rf_addr", rf_addr, 3);
    chk("ebreak halted", halted, 1);
    chk("ebreak in_ready", in_ready, 0);
    chk("ebreak retire_cnt", retire_cnt, 16);
    chk("ebreak retire_cnt4 wrap", retire_cnt4, 0);
    drive(1'b1, 32'hB0000008, 5'd5, 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("halt%0d commit_valid", i), commit_valid, 0);
      chk($sformatf("halt%0d rf_wen", i), rf_wen, 0);
      chk($sformatf("halt%0d in_ready", i), in_ready, 0);
      chk($sformatf("halt%0d halted", i), halted, 1);
      chk($sformatf("halt%0d retire_cnt", i), retire_cnt, 16);
    end
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt halted", halted, 0);
    chk("unhalt retire_cnt", retire_cnt, 0);
    chk("unhalt in_ready", in_ready, 1);
    tick();
    chk("unhalt commit_valid", commit_valid, 0);

    // 17 retirements wrap the 4-bit counter to 1
    for (int k = 0; k < 18; k++) begin
      if (k < 17) drive(1'b1, 32'hC0000000 + 32'(k * 4), 5'd6, 1'b1, 32'(k), 1'b0);
      else idle();
      tick();
    end
    chk("wrap retire_cnt", retire_cnt, 17);
    chk("wrap retire_cnt4", retire_cnt4, 1);
    chk("wrap last commit_pc", commit_pc, 32'hC0000040);

    // reset with two entries queued discards them
    stall = 1'b1;
    drive(1'b1, 32'hD0000000, 5'd8, 1'b1, 32'h88, 1'b0);
    tick();
    drive(1'b1, 32'hD0000004, 5'd9, 1'b1, 32'h99, 1'b0);
    tick();
    chk("queued in_ready", in_ready, 0);
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush%0d commit_valid", i), commit_valid, 0);
      chk($sformatf("flush%0d rf_wen", i), rf_wen, 0);
      chk($sformatf("flush%0d retire_cnt", i), retire_cnt, 0);
      chk($sformatf("flush%0d in_ready", i), in_ready, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
